// File: rtl/bcd_print_scheduler.sv
// bcd_print_scheduler: round-robin arbiter that converts one requester's value to BCD and streams it as ASCII digits plus a newline.
module bcd_print_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DIGITS  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*WIDTH-1:0] value,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  conv_start,
  output logic [WIDTH-1:0]      conv_binary,
  input  logic [DIGITS*4-1:0]   conv_bcd,
  input  logic                  conv_dv,
  output logic [7:0]            tx_data,
  output logic                  tx_new,
  input  logic                  tx_block,
  output logic                  busy
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT_CONV, SEND, GAP, DONE} state_t;
  state_t state;
  logic [GW-1:0] grant, last_grant, next_grant;
  logic [NUM_REQ-1:0] hi, sel;
  logic [WIDTH-1:0] next_value;
  logic [DIGITS*4-1:0] bcd;
  logic [DW-1:0] idx, msd;
  logic [3:0] digit;
  logic [7:0] ch;
  logic nl;
  // Requesters above the last grant win first; otherwise wrap to the lowest index.
  always_comb begin
    hi = '0;
    next_grant = '0;
    next_value = '0;
    for (int k = 0; k < NUM_REQ; k++) hi[k] = req[k] && (k > int'(last_grant));
    sel = |hi ? hi : req;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (sel[k]) begin
        next_grant = GW'(k);
        next_value = value[k*WIDTH +: WIDTH];
      end
  end
  always_comb begin
    msd = '0;
    for (int k = 0; k < DIGITS; k++) if (conv_bcd[k*4 +: 4] != 4'd0) msd = DW'(k);
  end
  assign digit = bcd[{idx, 2'b00} +: 4];
  assign ch = nl ? 8'h0A : digit > 4'd9 ? 8'h3F : {4'h3, digit};
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ack <= '0;
      conv_start <= 1'b0;
      conv_binary <= '0;
      tx_data <= '0;
      tx_new <= 1'b0;
      grant <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      bcd <= '0;
      idx <= '0;
      nl <= 1'b0;
    end else begin
      ack <= '0;
      conv_start <= 1'b0;
      tx_new <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          grant <= next_grant;
          conv_binary <= next_value;
          conv_start <= 1'b1;
          state <= START;
        end
        START: state <= WAIT_CONV;
        WAIT_CONV: if (conv_dv) begin
          bcd <= conv_bcd;
          idx <= msd;
          nl <= 1'b0;
          state <= SEND;
        end
        SEND: if (!tx_block) begin
          tx_new <= 1'b1;
          tx_data <= ch;
          state <= GAP;
        end
        GAP: begin
          state <= nl ? DONE : SEND;
          if (nl) ack <= NUM_REQ'(1) << grant;
          else if (idx == '0) nl <= 1'b1;
          else idx <= idx - 1'b1;
        end
        DONE: begin
          last_grant <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_print_scheduler.sv
// tb_bcd_print_scheduler: directed checks of arbitration, digit streaming, back-pressure and reset abandonment.
module tb_bcd_print_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [127:0] value = '0;
  logic [3:0] ack;
  logic conv_start;
  logic [31:0] conv_binary;
  logic [39:0] conv_bcd = '0;
  logic conv_dv = 1'b0;
  logic [7:0] tx_data;
  logic tx_new;
  logic tx_block = 1'b0;
  logic busy;
  int n_cmp = 0;
  int n_err = 0;
  int blk_viol = 0;
  int hot_viol = 0;
  logic blk_s = 1'b0;
  logic [7:0] rx_q[$];
  logic [3:0] ack_q[$];
  logic [31:0] cb_q[$];

  bcd_print_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .value(value), .ack(ack),
    .conv_start(conv_start), .conv_binary(conv_binary), .conv_bcd(conv_bcd),
    .conv_dv(conv_dv), .tx_data(tx_data), .tx_new(tx_new),
    .tx_block(tx_block), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) blk_s <= tx_block;

  always @(negedge clk) begin
    if (tx_new) rx_q.push_back(tx_data);
    if (|ack) ack_q.push_back(ack);
    if (conv_start) cb_q.push_back(conv_binary);
    if (tx_new && blk_s) blk_viol++;
    if ($countones(ack) > 1 || int'(conv_start) + int'(tx_new) + int'(|ack) > 1) hot_viol++;
  end

  // Converter model: result valid three cycles after the start pulse.
  always @(negedge clk) if (conv_start) begin
    repeat (3) @(negedge clk);
    conv_dv = 1'b1;
    @(negedge clk);
    conv_dv = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_q();
    rx_q.delete();
    ack_q.delete();
    cb_q.delete();
  endtask

  task automatic wait_acks(input int n);
    int c = 0;
    while (ack_q.size() < n && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("ack_wait", 64'(ack_q.size()), 64'(n));
    req = '0;
  endtask

  task automatic chk_str(input string tag, input string s);
    check({tag, "_len"}, 64'(rx_q.size()), 64'(s.len()));
    for (int i = 0; i < s.len() && i < rx_q.size(); i++) check(tag, 64'(rx_q[i]), 64'(s[i]));
  endtask

  task automatic print_one(input string tag, input logic [31:0] v, input logic [39:0] b, input string s);
    clear_q();
    @(negedge clk);
    value[31:0] = v;
    conv_bcd = b;
    req = 4'b0001;
    wait_acks(1);
    repeat (3) @(negedge clk);
    chk_str(tag, s);
    check({tag, "_ack"}, 64'(ack_q.size() > 0 ? ack_q[0] : 4'h0), 64'h1);
    check({tag, "_start"}, 64'(cb_q.size()), 64'd1);
    check({tag, "_bin"}, 64'(cb_q.size() > 0 ? cb_q[0] : 32'h0), 64'(v));
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_txnew", 64'(tx_new), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_start", 64'(conv_start), 64'd0);
    check("rst_bin", 64'(conv_binary), 64'd0);
    check("rst_txdata", 64'(tx_data), 64'd0);

    print_one("p1234", 32'd1234, 40'h1234, "1234\n");
    print_one("p0", 32'd0, 40'h0, "0\n");
    print_one("pmax", 32'hFFFF_FFFF, 40'h42_9496_7295, "4294967295\n");
    print_one("pbad", 32'd419, 40'h1A3, "1?3\n");

    do_reset();
    clear_q();
    for (int i = 0; i < 4; i++) value[i*32 +: 32] = 32'(100 + i);
    conv_bcd = 40'h5;
    @(negedge clk);
    req = 4'b1010;
    wait_acks(4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++) check("rr1010", 64'(ack_q[i]), i % 2 == 0 ? 64'h2 : 64'h8);
    for (int i = 0; i < 4 && i < cb_q.size(); i++) check("rr1010_bin", 64'(cb_q[i]), i % 2 == 0 ? 64'd101 : 64'd103);

    do_reset();
    clear_q();
    @(negedge clk);
    req = 4'b0101;
    wait_acks(2);
    for (int i = 0; i < 2 && i < ack_q.size(); i++) check("rr0101", 64'(ack_q[i]), i == 0 ? 64'h1 : 64'h4);

    do_reset();
    clear_q();
    value[31:0] = 32'd1234;
    conv_bcd = 40'h1234;
    @(negedge clk);
    req = 4'b0001;
    for (int c = 0; c < 200 && rx_q.size() < 1; c++) begin
      @(negedge clk);
      #1;
    end
    tx_block = 1'b1;
    repeat (5) @(negedge clk);
    check("blk_hold", 64'(rx_q.size()), 64'd1);
    tx_block = 1'b0;
    wait_acks(1);
    repeat (3) @(negedge clk);
    chk_str("blk", "1234\n");
    check("blk_viol", 64'(blk_viol), 64'd0);

    clear_q();
    tx_block = 1'b1;
    value[95:64] = 32'd77;
    @(negedge clk);
    req = 4'b0100;
    repeat (12) @(negedge clk);
    check("sendwait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_txnew", 64'(tx_new), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    tx_block = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_rx", 64'(rx_q.size()), 64'd0);
    check("rstmid_ack", 64'(ack_q.size()), 64'd0);
    clear_q();
    req = 4'b0101;
    wait_acks(1);
    repeat (3) @(negedge clk);
    check("after_rst_grant", 64'(ack_q.size() > 0 ? ack_q[0] : 4'h0), 64'h1);
    chk_str("after_rst", "1234\n");

    check("one_hot", 64'(hot_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
